control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer.sv | 171 +++++++++++++++++
 tb/tb_control_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Five-step microcode sequencer for a bus-based 8-bit CPU; controls are combinational from step/opcode/flags (0 cycles).
// No backpressure: the step counter advances every clock until HLT freezes it, and only reset clears it.
module control_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] opcode,
    input  logic       carry_flag,
    input  logic       zero_flag,
    output logic       pc_out,
    output logic       count_en,
    output logic       jump,
    output logic       mar_in,
    output logic       ram_out,
    output logic       ram_in,
    output logic       ir_in,
    output logic       ir_out,
    output logic       a_in,
    output logic       a_out,
    output logic       b_in,
    output logic       alu_out,
    output logic       alu_sub,
    output logic       flags_in,
    output logic       out_in,
    output logic       halt,
    output logic [2:0] step
);

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } step_e;

    localparam logic [3:0] OP_LDA = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_STA = 4'b0100;
    localparam logic [3:0] OP_LDI = 4'b0101;
    localparam logic [3:0] OP_JMP = 4'b0110;
    localparam logic [3:0] OP_JC  = 4'b0111;
    localparam logic [3:0] OP_JZ  = 4'b1000;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    step_e step_q, step_d;
    logic  halted_q, halted_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q   <= T0;
            halted_q <= 1'b0;
        end else begin
            step_q   <= step_d;
            halted_q <= halted_d;
        end
    end

    // HLT latches on the edge ending T2, so the frozen step value is T3.
    always_comb begin
        step_d   = step_q;
        halted_d = halted_q;
        if (!halted_q) begin
            case (step_q)
                T0:      step_d = T1;
                T1:      step_d = T2;
                T2:      step_d = T3;
                T3:      step_d = T4;
                default: step_d = T0;
            endcase
            if (step_q == T2 && opcode == OP_HLT) begin
                halted_d = 1'b1;
            end
        end
    end

    assign step = step_q;

    always_comb begin
        pc_out   = 1'b0;
        count_en = 1'b0;
        jump     = 1'b0;
        mar_in   = 1'b0;
        ram_out  = 1'b0;
        ram_in   = 1'b0;
        ir_in    = 1'b0;
        ir_out   = 1'b0;
        a_in     = 1'b0;
        a_out    = 1'b0;
        b_in     = 1'b0;
        alu_out  = 1'b0;
        alu_sub  = 1'b0;
        flags_in = 1'b0;
        out_in   = 1'b0;
        halt     = 1'b0;
        // Gating on rst_n keeps every control low during reset without waiting for a clock.
        if (rst_n && halted_q) begin
            halt = 1'b1;
        end else if (rst_n) begin
            case (step_q)
                T0: begin
                    pc_out = 1'b1;
                    mar_in = 1'b1;
                end
                T1: begin
                    ram_out  = 1'b1;
                    ir_in    = 1'b1;
                    count_en = 1'b1;
                end
                T2: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            ir_out = 1'b1;
                            mar_in = 1'b1;
                        end
                        OP_LDI: begin
                            ir_out = 1'b1;
                            a_in   = 1'b1;
                        end
                        OP_JMP: begin
                            ir_out = 1'b1;
                            jump   = 1'b1;
                        end
                        OP_JC: begin
                            ir_out = carry_flag;
                            jump   = carry_flag;
                        end
                        OP_JZ: begin
                            ir_out = zero_flag;
                            jump   = zero_flag;
                        end
                        OP_OUT: begin
                            a_out  = 1'b1;
                            out_in = 1'b1;
                        end
                        OP_HLT:  halt = 1'b1;
                        default: ;
                    endcase
                end
                T3: begin
                    case (opcode)
                        OP_LDA: begin
                            ram_out = 1'b1;
                            a_in    = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ram_out = 1'b1;
                            b_in    = 1'b1;
                        end
                        OP_STA: begin
                            a_out  = 1'b1;
                            ram_in = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T4: begin
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        alu_out  = 1'b1;
                        a_in     = 1'b1;
                        flags_in = 1'b1;
                        alu_sub  = (opcode == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-cycle vector table plus reset/halt/sweep sequences.
module tb_control_sequencer;

    logic       clk;
    logic       rst_n;
    logic [3:0] opcode;
    logic       carry_flag, zero_flag;
    logic       pc_out, count_en, jump, mar_in, ram_out, ram_in, ir_in, ir_out;
    logic       a_in, a_out, b_in, alu_out, alu_sub, flags_in, out_in, halt;
    logic [2:0] step;
    logic [15:0] ctrl;

    localparam logic [15:0] PC  = 16'h8000;
    localparam logic [15:0] CE  = 16'h4000;
    localparam logic [15:0] JP  = 16'h2000;
    localparam logic [15:0] MI  = 16'h1000;
    localparam logic [15:0] RO  = 16'h0800;
    localparam logic [15:0] RI  = 16'h0400;
    localparam logic [15:0] II  = 16'h0200;
    localparam logic [15:0] IO  = 16'h0100;
    localparam logic [15:0] AI  = 16'h0080;
    localparam logic [15:0] AO  = 16'h0040;
    localparam logic [15:0] BI  = 16'h0020;
    localparam logic [15:0] EO  = 16'h0010;
    localparam logic [15:0] SU  = 16'h0008;
    localparam logic [15:0] FI  = 16'h0004;
    localparam logic [15:0] OI  = 16'h0002;
    localparam logic [15:0] HL  = 16'h0001;
    localparam logic [15:0] BUS = PC | RO | IO | AO | EO;

    control_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .carry_flag (carry_flag),
        .zero_flag  (zero_flag),
        .pc_out     (pc_out),
        .count_en   (count_en),
        .jump       (jump),
        .mar_in     (mar_in),
        .ram_out    (ram_out),
        .ram_in     (ram_in),
        .ir_in      (ir_in),
        .ir_out     (ir_out),
        .a_in       (a_in),
        .a_out      (a_out),
        .b_in       (b_in),
        .alu_out    (alu_out),
        .alu_sub    (alu_sub),
        .flags_in   (flags_in),
        .out_in     (out_in),
        .halt       (halt),
        .step       (step)
    );

    assign ctrl = {pc_out, count_en, jump, mar_in, ram_out, ram_in, ir_in, ir_out,
                   a_in, a_out, b_in, alu_out, alu_sub, flags_in, out_in, halt};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic        c;
        logic        z;
        logic [2:0]  st;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Flags are only meaningful at T2, so the other rows carry the inverted flags.
    task automatic add_instr(input logic [3:0] op, input logic c, input logic z,
                             input logic [15:0] t2, input logic [15:0] t3, input logic [15:0] t4);
        vecs.push_back('{op, ~c, ~z, 3'd0, PC | MI});
        vecs.push_back('{op, ~c, ~z, 3'd1, RO | II | CE});
        vecs.push_back('{op,  c,  z, 3'd2, t2});
        vecs.push_back('{op, ~c, ~z, 3'd3, t3});
        vecs.push_back('{op, ~c, ~z, 3'd4, t4});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        rst_n      = 1'b0;
        opcode     = 4'hF;
        carry_flag = 1'b1;
        zero_flag  = 1'b1;
        #1;
        check("reset_step", {13'd0, step}, 16'd0);
        check("reset_ctrl", ctrl, 16'h0000);
        repeat (2) @(negedge clk);
        check("reset_clk_step", {13'd0, step}, 16'd0);
        check("reset_clk_ctrl", ctrl, 16'h0000);

        add_instr(4'h1, 1'b0, 1'b0, IO | MI, RO | AI, 16'h0);
        add_instr(4'h2, 1'b0, 1'b0, IO | MI, RO | BI, EO | AI | FI);
        add_instr(4'h3, 1'b0, 1'b0, IO | MI, RO | BI, EO | SU | AI | FI);
        add_instr(4'h4, 1'b0, 1'b0, IO | MI, AO | RI, 16'h0);
        add_instr(4'h5, 1'b0, 1'b0, IO | AI, 16'h0, 16'h0);
        add_instr(4'h6, 1'b0, 1'b0, IO | JP, 16'h0, 16'h0);
        add_instr(4'h7, 1'b0, 1'b1, 16'h0, 16'h0, 16'h0);
        add_instr(4'h7, 1'b1, 1'b0, IO | JP, 16'h0, 16'h0);
        add_instr(4'h8, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0);
        add_instr(4'h8, 1'b0, 1'b1, IO | JP, 16'h0, 16'h0);
        add_instr(4'hE, 1'b0, 1'b0, AO | OI, 16'h0, 16'h0);
        add_instr(4'h0, 1'b1, 1'b1, 16'h0, 16'h0, 16'h0);
        for (int op = 9; op <= 13; op++)
            add_instr(4'(op), 1'b1, 1'b1, 16'h0, 16'h0, 16'h0);

        rst_n = 1'b1;
        foreach (vecs[i]) begin
            opcode     = vecs[i].op;
            carry_flag = vecs[i].c;
            zero_flag  = vecs[i].z;
            #1;
            check($sformatf("vec%0d_op%h_step", i, vecs[i].op), {13'd0, step}, {13'd0, vecs[i].st});
            check($sformatf("vec%0d_op%h_ctrl", i, vecs[i].op), ctrl, vecs[i].exp);
            @(negedge clk);
        end

        // Reset mid-ADD at T3, held across clocks, then fetch resumes.
        opcode = 4'h2;
        repeat (3) @(negedge clk);
        #1;
        check("add_t3_step", {13'd0, step}, 16'd3);
        check("add_t3_ctrl", ctrl, RO | BI);
        rst_n = 1'b0;
        #1;
        check("add_rst_step", {13'd0, step}, 16'd0);
        check("add_rst_ctrl", ctrl, 16'h0000);
        repeat (2) @(negedge clk);
        check("add_rst_hold_ctrl", ctrl, 16'h0000);
        rst_n = 1'b1;
        #1;
        check("add_rel_t0_ctrl", ctrl, PC | MI);
        @(negedge clk);
        check("add_rel_t1_step", {13'd0, step}, 16'd1);
        check("add_rel_t1_ctrl", ctrl, RO | II | CE);
        repeat (4) @(negedge clk);

        // Sweep non-halting opcodes: at most one bus driver, count_en only at T1.
        carry_flag = 1'b1;
        zero_flag  = 1'b1;
        for (int op = 0; op <= 14; op++) begin
            opcode = 4'(op);
            for (int s = 0; s < 5; s++) begin
                #1;
                nb = $countones(ctrl & BUS);
                tests++;
                if (nb > 1) begin
                    fails++;
                    $display("FAIL sweep_bus op%h T%0d: got %0d drivers, expected <=1", op, s, nb);
                end
                check($sformatf("sweep_step op%h T%0d", op, s), {13'd0, step}, 16'(s));
                check($sformatf("sweep_ce op%h T%0d", op, s), {15'd0, count_en}, {15'd0, s == 1});
                @(negedge clk);
            end
        end

        // HLT: halt asserted at T2, then frozen at step 3 ignoring inputs.
        opcode = 4'hF;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("hlt_t2_step", {13'd0, step}, 16'd2);
        check("hlt_t2_ctrl", ctrl, HL);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            opcode     = 4'($urandom_range(0, 15));
            carry_flag = 1'($urandom_range(0, 1));
            zero_flag  = 1'($urandom_range(0, 1));
            #1;
            check($sformatf("halted%0d_step", k), {13'd0, step}, 16'd3);
            check($sformatf("halted%0d_ctrl", k), ctrl, HL);
        end

        rst_n = 1'b0;
        #1;
        check("hlt_rst_step", {13'd0, step}, 16'd0);
        check("hlt_rst_ctrl", ctrl, 16'h0000);
        @(negedge clk);
        rst_n  = 1'b1;
        opcode = 4'h1;
        #1;
        check("hlt_rel_t0_ctrl", ctrl, PC | MI);
        @(negedge clk);
        check("hlt_rel_t1_step", {13'd0, step}, 16'd1);
        check("hlt_rel_t1_ctrl", ctrl, RO | II | CE);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
